// File: rtl/simd_alu_pkg.sv
// Shared types for the SIMD ALU pipeline.
// Accumulate mode is built only when SIMD_ALU_ACC_EN is defined.
package simd_alu_pkg;

    localparam int AluCfgWidth = 3;

    typedef enum logic [AluCfgWidth-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_MUL = 3'd2,
        ALU_XOR = 3'd3,
        ALU_ACC = 3'd4
    } alu_op_e;

endpackage

// File: rtl/simd_alu_lane.sv
// One SIMD lane: combinational op mux plus, with SIMD_ALU_ACC_EN,
// the lane's multiply-accumulate register.
module simd_alu_lane
    import simd_alu_pkg::*;
#(
    parameter int DataWidth = 64
) (
`ifdef SIMD_ALU_ACC_EN
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 acc_first_i,
    input  logic                 acc_we_i,
`endif
    input  logic [DataWidth-1:0] a_i,
    input  logic [DataWidth-1:0] b_i,
    input  alu_op_e              op_i,
    output logic [DataWidth-1:0] res_o
);

    logic [DataWidth-1:0] w_prod;

    assign w_prod = a_i * b_i;

`ifdef SIMD_ALU_ACC_EN
    logic [DataWidth-1:0] r_acc;
    logic [DataWidth-1:0] w_acc_sum;

    // First beat of a group ignores whatever an aborted group left behind
    assign w_acc_sum = (acc_first_i ? '0 : r_acc) + w_prod;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc <= '0;
        end else if (acc_we_i) begin
            r_acc <= w_acc_sum;
        end
    end
`endif

    always_comb begin
        res_o = '0;
        unique case (op_i)
            ALU_ADD: res_o = a_i + b_i;
            ALU_SUB: res_o = a_i - b_i;
            ALU_MUL: res_o = w_prod;
            ALU_XOR: res_o = a_i ^ b_i;
`ifdef SIMD_ALU_ACC_EN
            ALU_ACC: res_o = w_acc_sum;
`endif
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/simd_alu_pipe.sv
// Elastic SIMD ALU pipeline: compute in stage 0, holding stages after.
// Define SIMD_ALU_ACC_EN to build the multiply-accumulate mode.
module simd_alu_pipe
    import simd_alu_pkg::*;
#(
    parameter int SpatPar    = 4,
    parameter int DataWidth  = 64,
    parameter int PipeStages = 2,
    parameter int CntWidth   = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [SpatPar*DataWidth-1:0] a_i,
    input  logic                         a_valid_i,
    output logic                         a_ready_o,
    input  logic [SpatPar*DataWidth-1:0] b_i,
    input  logic                         b_valid_i,
    output logic                         b_ready_o,
    output logic [SpatPar*DataWidth-1:0] result_o,
    output logic                         result_valid_o,
    input  logic                         result_ready_i,
    input  logic [AluCfgWidth-1:0]       alu_config_i,
    input  logic [CntWidth-1:0]          acc_len_i,
    output logic                         busy_o
);

    localparam int LaneW = SpatPar * DataWidth;

    alu_op_e           w_op;
    logic [LaneW-1:0]  w_res;
    logic              w_fire;
    logic              w_push;
    logic              w_ready;
    logic [PipeStages-1:0] w_adv;
    logic [PipeStages-1:0] r_vld;
    logic [LaneW-1:0]  r_dat [PipeStages];

    assign w_op   = alu_op_e'(alu_config_i);
    assign w_fire = a_valid_i & b_valid_i & w_ready;

    // Stage k may move on if the output is taken or any later slot is free
    always_comb begin
        w_adv = '0;
        for (int k = 0; k < PipeStages; k++) begin
            w_adv[k] = result_ready_i;
            for (int j = k + 1; j < PipeStages; j++) begin
                if (!r_vld[j]) w_adv[k] = 1'b1;
            end
        end
    end

    assign w_ready   = !r_vld[0] | w_adv[0];
    assign a_ready_o = w_ready;
    assign b_ready_o = w_ready;

`ifdef SIMD_ALU_ACC_EN
    logic                w_is_acc;
    logic                w_last;
    logic                w_acc_first;
    logic                w_acc_we;
    logic [CntWidth-1:0] w_len;
    logic [CntWidth-1:0] w_cnt_inc;
    logic [CntWidth-1:0] r_cnt;
    logic [CntWidth-1:0] r_len;

    assign w_is_acc    = (w_op == ALU_ACC);
    assign w_acc_first = (r_cnt == '0);
    assign w_acc_we    = w_fire & w_is_acc;
    assign w_cnt_inc   = r_cnt + CntWidth'(1);
    assign w_len       = !w_acc_first ? r_len :
                         (acc_len_i == '0) ? CntWidth'(1) : acc_len_i;
    assign w_last      = w_is_acc & (w_cnt_inc == w_len);
    assign w_push      = w_fire & (!w_is_acc | w_last);
    assign busy_o      = (|r_vld) | !w_acc_first;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
            r_len <= '0;
        end else if (w_fire) begin
            r_cnt <= (w_is_acc && !w_last) ? w_cnt_inc : '0;
            if (w_acc_first) r_len <= w_len;
        end
    end
`else
    logic [CntWidth-1:0] w_unused_len;

    assign w_unused_len = acc_len_i;
    assign w_push       = w_fire;
    assign busy_o       = |r_vld;
`endif

    for (genvar i = 0; i < SpatPar; i++) begin : g_lane
        simd_alu_lane #(
            .DataWidth (DataWidth)
        ) u_lane (
`ifdef SIMD_ALU_ACC_EN
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .acc_first_i (w_acc_first),
            .acc_we_i    (w_acc_we),
`endif
            .a_i         (a_i[i*DataWidth +: DataWidth]),
            .b_i         (b_i[i*DataWidth +: DataWidth]),
            .op_i        (w_op),
            .res_o       (w_res[i*DataWidth +: DataWidth])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld <= '0;
            for (int k = 0; k < PipeStages; k++) r_dat[k] <= '0;
        end else begin
            if (w_ready) begin
                r_vld[0] <= w_push;
                if (w_push) r_dat[0] <= w_res;
            end
            for (int k = 1; k < PipeStages; k++) begin
                if (!r_vld[k] || w_adv[k]) begin
                    r_vld[k] <= r_vld[k-1];
                    r_dat[k] <= r_dat[k-1];
                end
            end
        end
    end

    assign result_o       = r_dat[PipeStages-1];
    assign result_valid_o = r_vld[PipeStages-1];

endmodule

// File: tb/tb_simd_alu_pipe.sv
// Directed bench for simd_alu_pipe (4 lanes x 16 bits, 2 stages).
// ACC scenarios are compiled in when SIMD_ALU_ACC_EN is defined.
module tb_simd_alu_pipe;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [63:0] a_i, b_i, result_o;
    logic        a_valid_i, b_valid_i, a_ready_o, b_ready_o;
    logic        result_valid_o, result_ready_i, busy_o;
    logic [2:0]  alu_config_i;
    logic [15:0] acc_len_i;

    int          n_err = 0;
    int          n_chk = 0;
    int          pi, ci, nv;
    logic        fire;
    logic [63:0] held;
    logic [63:0] exp_q [5];

    always #5 clk = ~clk;

    simd_alu_pipe #(
        .SpatPar    (4),
        .DataWidth  (16),
        .PipeStages (2),
        .CntWidth   (16)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .a_i            (a_i),
        .a_valid_i      (a_valid_i),
        .a_ready_o      (a_ready_o),
        .b_i            (b_i),
        .b_valid_i      (b_valid_i),
        .b_ready_o      (b_ready_o),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .alu_config_i   (alu_config_i),
        .acc_len_i      (acc_len_i),
        .busy_o         (busy_o)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic [15:0] x0, input logic [15:0] x1,
                                       input logic [15:0] x2, input logic [15:0] x3);
        return {x3, x2, x1, x0};
    endfunction

    function automatic logic [63:0] rep(input logic [15:0] x);
        return {4{x}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] op, input logic [15:0] len);
        int n;
        a_i = a; b_i = b; alu_config_i = op; acc_len_i = len;
        a_valid_i = 1'b1; b_valid_i = 1'b1;
        #1;
        n = 0;
        while (!a_ready_o && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("beat_timeout", 64'(a_ready_o), 64'd1);
        tick();
        a_valid_i = 1'b0; b_valid_i = 1'b0;
    endtask

    task automatic expect_res(input string tag, input logic [63:0] exp);
        int n;
        n = 0;
        while (!result_valid_o && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 64'(result_valid_o), 64'd1);
        check(tag, result_o, exp);
        tick();
    endtask

    task automatic count_idle(input string tag, input int cycles);
        nv = 0;
        for (int i = 0; i < cycles; i++) begin
            if (result_valid_o) nv++;
            tick();
        end
        check(tag, 64'(nv), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0;
        a_i = '0; b_i = '0; alu_config_i = '0; acc_len_i = '0;
        a_valid_i = 1'b0; b_valid_i = 1'b0; result_ready_i = 1'b1;
        tick();
        tick();
        check("rst_valid", 64'(result_valid_o), 64'd0);
        check("rst_result", result_o, 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_ready", {62'd0, a_ready_o, b_ready_o}, 64'd3);
        rst_ni = 1'b1;
        tick();

        // ADD with exact two-cycle latency
        a_i = pk(1, 2, 3, 4); b_i = pk(10, 20, 30, 40);
        alu_config_i = 3'd0; a_valid_i = 1'b1; b_valid_i = 1'b1;
        #1;
        check("add_ready", {62'd0, a_ready_o, b_ready_o}, 64'd3);
        tick();
        a_valid_i = 1'b0; b_valid_i = 1'b0;
        check("add_lat1", 64'(result_valid_o), 64'd0);
        check("add_busy", 64'(busy_o), 64'd1);
        tick();
        check("add_lat2", 64'(result_valid_o), 64'd1);
        check("add_res", result_o, pk(11, 22, 33, 44));
        tick();

        beat(rep(16'd0), rep(16'd1), 3'd1, 16'd0);
        expect_res("sub_wrap", rep(16'hFFFF));
        beat(rep(16'h0100), rep(16'h0100), 3'd2, 16'd0);
        expect_res("mul_wrap", 64'd0);
        beat(pk(3, 5, 7, 16'hFFFF), pk(3, 6, 9, 16'h0F0F), 3'd2, 16'd0);
        expect_res("mul_lanes", pk(9, 30, 63, 16'hF0F1));
        beat(pk(16'h00FF, 1, 2, 3), pk(16'h0F0F, 1, 3, 16'hFFFF), 3'd3, 16'd0);
        expect_res("xor", pk(16'h0FF0, 0, 1, 16'hFFFC));
        beat(rep(16'd5), rep(16'd7), 3'd6, 16'd0);
        expect_res("op6_zero", 64'd0);

        // Backpressure: output stalled for three cycles with five beats queued
        for (int i = 0; i < 5; i++)
            exp_q[i] = pk(16'(101 + i), 16'(102 + i), 16'(103 + i), 16'(104 + i));
        pi = 0; ci = 0; held = '0;
        for (int cyc = 0; cyc < 40 && ci < 5; cyc++) begin
            result_ready_i = (cyc >= 5);
            a_valid_i = (pi < 5); b_valid_i = (pi < 5);
            a_i = pk(16'(pi + 1), 16'(pi + 2), 16'(pi + 3), 16'(pi + 4));
            b_i = rep(16'd100); alu_config_i = 3'd0;
            #1;
            if (cyc == 2) begin
                check("bp_ready_drop", 64'(a_ready_o), 64'd0);
                held = result_o;
            end
            if (cyc == 3 || cyc == 4) begin
                check("bp_stable", result_o, held);
                check("bp_hold_valid", 64'(result_valid_o), 64'd1);
            end
            if (result_valid_o && result_ready_i) begin
                check("bp_order", result_o, exp_q[ci]);
                ci++;
            end
            fire = a_valid_i & a_ready_o;
            tick();
            if (fire) pi++;
        end
        a_valid_i = 1'b0; b_valid_i = 1'b0; result_ready_i = 1'b1;
        check("bp_count", 64'(ci), 64'd5);
        count_idle("bp_no_extra", 3);

        // A alone never fires
        a_i = pk(7, 8, 9, 10); b_i = rep(16'd1); alu_config_i = 3'd0;
        a_valid_i = 1'b1; b_valid_i = 1'b0;
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (result_valid_o || busy_o) nv++;
        end
        check("joint_a_alone", 64'(nv), 64'd0);
        b_valid_i = 1'b1;
        tick();
        a_valid_i = 1'b0; b_valid_i = 1'b0;
        expect_res("joint_one", pk(8, 9, 10, 11));
        count_idle("joint_no_extra", 4);

`ifdef SIMD_ALU_ACC_EN
        result_ready_i = 1'b0;
        beat(rep(16'd1), rep(16'd1), 3'd4, 16'd3);
        beat(rep(16'd2), rep(16'd2), 3'd4, 16'd9);
        beat(rep(16'd3), rep(16'd3), 3'd4, 16'd9);
        result_ready_i = 1'b1;
        expect_res("acc_len3", rep(16'd14));
        count_idle("acc_single", 4);

        result_ready_i = 1'b0;
        beat(rep(16'd2), rep(16'd3), 3'd4, 16'd0);
        beat(rep(16'd4), rep(16'd5), 3'd4, 16'd0);
        result_ready_i = 1'b1;
        expect_res("acc_len0_a", rep(16'd6));
        expect_res("acc_len0_b", rep(16'd20));

        result_ready_i = 1'b0;
        beat(rep(16'd1), rep(16'd1), 3'd4, 16'd3);
        beat(rep(16'd1), rep(16'd1), 3'd4, 16'd3);
        beat(rep(16'd5), rep(16'd6), 3'd0, 16'd0);
        beat(rep(16'd2), rep(16'd2), 3'd4, 16'd2);
        beat(rep(16'd3), rep(16'd3), 3'd4, 16'd0);
        result_ready_i = 1'b1;
        expect_res("acc_abort_add", rep(16'd11));
        expect_res("acc_restart", rep(16'd13));
        count_idle("acc_abort_quiet", 3);

        // Reset with a result held and an open group at cnt=2
        result_ready_i = 1'b0;
        beat(rep(16'd9), rep(16'd1), 3'd0, 16'd0);
        beat(rep(16'd1), rep(16'd1), 3'd4, 16'd4);
        beat(rep(16'd1), rep(16'd1), 3'd4, 16'd0);
        tick();
        check("rst_pre_busy", 64'(busy_o), 64'd1);
`else
        beat(rep(16'd3), rep(16'd4), 3'd4, 16'd5);
        expect_res("op4_reserved", 64'd0);

        result_ready_i = 1'b0;
        beat(rep(16'd9), rep(16'd1), 3'd0, 16'd0);
        beat(rep(16'd8), rep(16'd1), 3'd0, 16'd0);
        tick();
        check("rst_pre_full", 64'(a_ready_o), 64'd0);
`endif
        rst_ni = 1'b0;
        #1;
        check("rst_mid_valid", 64'(result_valid_o), 64'd0);
        check("rst_mid_busy", 64'(busy_o), 64'd0);
        tick();
        rst_ni = 1'b1;
        result_ready_i = 1'b1;
        tick();
        count_idle("rst_no_stale", 4);
`ifdef SIMD_ALU_ACC_EN
        beat(rep(16'd2), rep(16'd3), 3'd4, 16'd1);
        expect_res("rst_acc_after", rep(16'd6));
`else
        beat(rep(16'd2), rep(16'd3), 3'd0, 16'd0);
        expect_res("rst_add_after", rep(16'd5));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
